spiker_run_ctrl: RTL

Run controller for the spiker adapter. It sequences one inference run of N timesteps: it kicks the spiking core, waits for the core's timestep completion, and pulses the sample strobe of the result writer. It then waits for the writer to become ready and issues a final flush sample, so that the last timestep's spikes reach the register file. It sits between the register-file control fields (start/abort/step count) and the core/writer datapath, and reports busy, done and timeout status back to the register file.

---
 rtl/spiker_run_ctrl_if.sv | 27 ++
 rtl/spiker_run_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/spiker_run_ctrl_if.sv
// Control/status bundle between the register file, spiking core and result writer
// and the spiker run controller.
interface spiker_run_ctrl_if #(
  parameter int unsigned STEP_W = 16
);
  logic              start_i;
  logic              abort_i;
  logic [STEP_W-1:0] n_steps_i;
  logic              core_start_o;
  logic              core_done_i;
  logic              sample_o;
  logic              writer_ready_i;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;
  logic [STEP_W-1:0] step_cnt_o;

  modport master (
    output start_i, abort_i, n_steps_i, core_done_i, writer_ready_i,
    input  core_start_o, sample_o, busy_o, done_o, timeout_o, step_cnt_o
  );

  modport slave (
    input  start_i, abort_i, n_steps_i, core_done_i, writer_ready_i,
    output core_start_o, sample_o, busy_o, done_o, timeout_o, step_cnt_o
  );
endinterface

// File: rtl/spiker_run_ctrl.sv
// Sequences one inference run: kick core, wait for timestep, sample writer,
// repeat N times, then flush the writer's lagging result registers.
module spiker_run_ctrl #(
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spiker_run_ctrl_if.slave bus
);
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_KICK      = 3'd1;
  localparam logic [2:0] S_WAIT_CORE = 3'd2;
  localparam logic [2:0] S_SAMPLE    = 3'd3;
  localparam logic [2:0] S_WAIT_WR   = 3'd4;
  localparam logic [2:0] S_FLUSH     = 3'd5;
  localparam logic [2:0] S_WAIT_FL   = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [STEP_W-1:0] n_steps_q, n_steps_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] step_inc;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic              wait_expired;
  logic              core_start_q, sample_q, busy_q, done_q;

  assign step_inc     = step_cnt_q + STEP_W'(1);
  assign wait_expired = (to_cnt_q == TO_LAST);

  // Next-state, counters and sticky error
  always_comb begin
    state_d    = state_q;
    n_steps_d  = n_steps_q;
    step_cnt_d = step_cnt_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;

    if (state_q != S_IDLE && bus.abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            n_steps_d  = bus.n_steps_i;
            step_cnt_d = '0;
            timeout_d  = 1'b0;
            state_d    = (bus.n_steps_i == '0) ? S_DONE : S_KICK;
          end
        end
        S_KICK: begin
          to_cnt_d = '0;
          state_d  = S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (bus.core_done_i) begin
            state_d = S_SAMPLE;
          end else if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_SAMPLE: begin
          to_cnt_d = '0;
          state_d  = S_WAIT_WR;
        end
        S_WAIT_WR: begin
          if (bus.writer_ready_i) begin
            step_cnt_d = step_inc;
            state_d    = (step_inc == n_steps_q) ? S_FLUSH : S_KICK;
          end else if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_FLUSH: begin
          to_cnt_d = '0;
          state_d  = S_WAIT_FL;
        end
        S_WAIT_FL: begin
          if (bus.writer_ready_i) begin
            state_d = S_DONE;
          end else if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulses and status are registered from the next state, so they align with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      n_steps_q    <= '0;
      step_cnt_q   <= '0;
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      core_start_q <= 1'b0;
      sample_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_steps_q    <= n_steps_d;
      step_cnt_q   <= step_cnt_d;
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
      core_start_q <= (state_d == S_KICK);
      sample_q     <= (state_d == S_SAMPLE) || (state_d == S_FLUSH);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.core_start_o = core_start_q;
  assign bus.sample_o     = sample_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.step_cnt_o   = step_cnt_q;
endmodule
